// File: rtl/keycode_arbiter.sv
// Two-player keycode arbiter: decodes left/right/up per player from packed USB slots,
// resolves SOCD conflicts and emits jump pulses; optional KEYCODE_ARBITER_DEBOUNCE_EN.

module keycode_arbiter_player #(
    parameter int         SOCD_MODE = 0,
    parameter logic [7:0] LEFT      = 8'h50,
    parameter logic [7:0] RIGHT     = 8'h4F,
    parameter logic [7:0] UP        = 8'h52
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_tick,
    input  logic        i_raw_l,
    input  logic        i_raw_r,
    input  logic        i_raw_u,
    output logic [15:0] o_code,
    output logic        o_jump,
    output logic        o_conflict
);
    typedef enum logic [1:0] {DIR_NONE, DIR_LEFT, DIR_RIGHT} dir_t;

    logic w_l, w_r, w_u;

`ifdef KEYCODE_ARBITER_DEBOUNCE_EN
    // A press counts only once the raw key was also present at the previous tick.
    logic r_conf_l, r_conf_r, r_conf_u;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_conf_l <= 1'b0;
            r_conf_r <= 1'b0;
            r_conf_u <= 1'b0;
        end else if (frame_tick) begin
            r_conf_l <= i_raw_l;
            r_conf_r <= i_raw_r;
            r_conf_u <= i_raw_u;
        end
    end

    assign w_l = i_raw_l & r_conf_l;
    assign w_r = i_raw_r & r_conf_r;
    assign w_u = i_raw_u & r_conf_u;
`else
    assign w_l = i_raw_l;
    assign w_r = i_raw_r;
    assign w_u = i_raw_u;
`endif

    logic        r_pl, r_pr, r_pu;
    dir_t        r_last, w_last_nxt;
    logic        w_rose_l, w_rose_r;
    logic [7:0]  w_horiz;
    logic [15:0] r_code;
    logic        r_jump, r_conflict;

    assign w_rose_l = w_l & ~r_pl;
    assign w_rose_r = w_r & ~r_pr;

    always_comb begin
        w_last_nxt = r_last;
        if (w_rose_l && !w_rose_r)      w_last_nxt = DIR_LEFT;
        else if (w_rose_r && !w_rose_l) w_last_nxt = DIR_RIGHT;
        else if (w_rose_l && w_rose_r)  w_last_nxt = DIR_NONE;
    end

    // Both held: neutral, or the direction decided on this very tick.
    always_comb begin
        w_horiz = 8'h00;
        case ({w_l, w_r})
            2'b10: w_horiz = LEFT;
            2'b01: w_horiz = RIGHT;
            2'b11: begin
                if (SOCD_MODE == 1) begin
                    if (w_last_nxt == DIR_LEFT)       w_horiz = LEFT;
                    else if (w_last_nxt == DIR_RIGHT) w_horiz = RIGHT;
                end
            end
            default: w_horiz = 8'h00;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_pl       <= 1'b0;
            r_pr       <= 1'b0;
            r_pu       <= 1'b0;
            r_last     <= DIR_NONE;
            r_code     <= 16'h0000;
            r_jump     <= 1'b0;
            r_conflict <= 1'b0;
        end else if (frame_tick) begin
            r_pl       <= w_l;
            r_pr       <= w_r;
            r_pu       <= w_u;
            r_last     <= w_last_nxt;
            r_code     <= {(w_u ? UP : 8'h00), w_horiz};
            r_jump     <= w_u & ~r_pu;
            r_conflict <= w_l & w_r;
        end else begin
            r_jump     <= 1'b0;
        end
    end

    assign o_code     = r_code;
    assign o_jump     = r_jump;
    assign o_conflict = r_conflict;
endmodule

module keycode_arbiter #(
    parameter int         SLOTS      = 4,
    parameter int         SOCD_MODE  = 0,
    parameter logic [7:0] BOY_LEFT   = 8'h50,
    parameter logic [7:0] BOY_RIGHT  = 8'h4F,
    parameter logic [7:0] BOY_UP     = 8'h52,
    parameter logic [7:0] GIRL_LEFT  = 8'h04,
    parameter logic [7:0] GIRL_RIGHT = 8'h07,
    parameter logic [7:0] GIRL_UP    = 8'h1A
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_tick,
    input  logic [8*SLOTS-1:0] keycodes,
    output logic [15:0]        keycode_boy,
    output logic [15:0]        keycode_girl,
    output logic               jump_boy,
    output logic               jump_girl,
    output logic               conflict_boy,
    output logic               conflict_girl
);
    // w_raw bit order: boy L/R/U, girl L/R/U
    logic [5:0] w_raw;

    always_comb begin
        logic [7:0] slot;
        w_raw = 6'b0;
        for (int i = 0; i < SLOTS; i++) begin
            slot = keycodes[8*i +: 8];
            if (slot != 8'h00) begin
                if (slot == BOY_LEFT)   w_raw[0] = 1'b1;
                if (slot == BOY_RIGHT)  w_raw[1] = 1'b1;
                if (slot == BOY_UP)     w_raw[2] = 1'b1;
                if (slot == GIRL_LEFT)  w_raw[3] = 1'b1;
                if (slot == GIRL_RIGHT) w_raw[4] = 1'b1;
                if (slot == GIRL_UP)    w_raw[5] = 1'b1;
            end
        end
    end

    keycode_arbiter_player #(
        .SOCD_MODE(SOCD_MODE), .LEFT(BOY_LEFT), .RIGHT(BOY_RIGHT), .UP(BOY_UP)
    ) u_boy (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .i_raw_l(w_raw[0]), .i_raw_r(w_raw[1]), .i_raw_u(w_raw[2]),
        .o_code(keycode_boy), .o_jump(jump_boy), .o_conflict(conflict_boy)
    );

    keycode_arbiter_player #(
        .SOCD_MODE(SOCD_MODE), .LEFT(GIRL_LEFT), .RIGHT(GIRL_RIGHT), .UP(GIRL_UP)
    ) u_girl (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick),
        .i_raw_l(w_raw[3]), .i_raw_r(w_raw[4]), .i_raw_u(w_raw[5]),
        .o_code(keycode_girl), .o_jump(jump_girl), .o_conflict(conflict_girl)
    );
endmodule

// File: tb/tb_keycode_arbiter.sv
// Randomized + directed bench for keycode_arbiter: dut0 is SOCD_MODE=0/SLOTS=6,
// dut1 is SOCD_MODE=1/SLOTS=4, both checked against a set-based reference model.

module tb_keycode_arbiter;
    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic [47:0] kc0 = '0;
    logic [31:0] kc1 = '0;
    logic [15:0] kb [2];
    logic [15:0] kg [2];
    logic        jb [2];
    logic        jg [2];
    logic        cb [2];
    logic        cg [2];

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    keycode_arbiter #(.SLOTS(6), .SOCD_MODE(0)) dut0 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycodes(kc0),
        .keycode_boy(kb[0]), .keycode_girl(kg[0]), .jump_boy(jb[0]), .jump_girl(jg[0]),
        .conflict_boy(cb[0]), .conflict_girl(cg[0])
    );

    keycode_arbiter #(.SLOTS(4), .SOCD_MODE(1)) dut1 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycodes(kc1),
        .keycode_boy(kb[1]), .keycode_girl(kg[1]), .jump_boy(jb[1]), .jump_girl(jg[1]),
        .conflict_boy(cb[1]), .conflict_girl(cg[1])
    );

    // Reference model: per dut/player, remembered key sets and last-pressed direction.
    int          m_last [2][2];   // 0 none, 1 left, 2 right
    bit          m_prev [2][2][3];
    bit          m_conf [2][2][3];
    logic [15:0] e_code [2][2];
    bit          e_jump [2][2];
    bit          e_conf [2][2];

    function automatic logic [7:0] key_code(int p, int k);
        logic [7:0] boy  [3] = '{8'h50, 8'h4F, 8'h52};
        logic [7:0] girl [3] = '{8'h04, 8'h07, 8'h1A};
        return (p == 0) ? boy[k] : girl[k];
    endfunction

    function automatic bit present(int d, logic [7:0] k);
        logic [47:0] kc;
        int n;
        kc = (d == 0) ? kc0 : {16'h0000, kc1};
        n  = (d == 0) ? 6 : 4;
        if (k == 8'h00) return 1'b0;
        for (int i = 0; i < n; i++)
            if (kc[8*i +: 8] == k) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_edge(input logic rst_n, input logic tick);
        bit cur [3];
        bit raw, rl, rr;
        logic [7:0] h;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rst_n) begin
                    m_last[d][p] = 0;
                    for (int k = 0; k < 3; k++) begin
                        m_prev[d][p][k] = 1'b0;
                        m_conf[d][p][k] = 1'b0;
                    end
                    e_code[d][p] = 16'h0000;
                    e_jump[d][p] = 1'b0;
                    e_conf[d][p] = 1'b0;
                end else if (tick) begin
                    for (int k = 0; k < 3; k++) begin
                        raw = present(d, key_code(p, k));
`ifdef KEYCODE_ARBITER_DEBOUNCE_EN
                        cur[k] = raw && m_conf[d][p][k];
                        m_conf[d][p][k] = raw;
`else
                        cur[k] = raw;
`endif
                    end
                    rl = cur[0] && !m_prev[d][p][0];
                    rr = cur[1] && !m_prev[d][p][1];
                    if (rl && !rr)      m_last[d][p] = 1;
                    else if (rr && !rl) m_last[d][p] = 2;
                    else if (rl && rr)  m_last[d][p] = 0;
                    if (cur[0] && !cur[1])      h = key_code(p, 0);
                    else if (cur[1] && !cur[0]) h = key_code(p, 1);
                    else if (cur[0] && cur[1] && d == 1 && m_last[d][p] != 0)
                        h = key_code(p, m_last[d][p] - 1);
                    else                        h = 8'h00;
                    e_code[d][p] = {(cur[2] ? key_code(p, 2) : 8'h00), h};
                    e_jump[d][p] = cur[2] && !m_prev[d][p][2];
                    e_conf[d][p] = cur[0] && cur[1];
                    for (int k = 0; k < 3; k++) m_prev[d][p][k] = cur[k];
                end else begin
                    e_jump[d][p] = 1'b0;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("kb%0d", d), kb[d], e_code[d][0]);
            chk($sformatf("kg%0d", d), kg[d], e_code[d][1]);
            chk($sformatf("jb%0d", d), {15'h0, jb[d]}, {15'h0, e_jump[d][0]});
            chk($sformatf("jg%0d", d), {15'h0, jg[d]}, {15'h0, e_jump[d][1]});
            chk($sformatf("cb%0d", d), {15'h0, cb[d]}, {15'h0, e_conf[d][0]});
            chk($sformatf("cg%0d", d), {15'h0, cg[d]}, {15'h0, e_conf[d][1]});
        end
    endtask

    // Inputs change just after an edge; outputs are compared 1 time unit after the edge.
    task automatic step(input logic rst_n, input logic tick, input logic [47:0] k0, input logic [31:0] k1);
        Reset_n    = rst_n;
        frame_tick = tick;
        kc0        = k0;
        kc1        = k1;
        @(posedge Clk);
        model_edge(rst_n, tick);
        #1;
        check_all();
    endtask

    logic [7:0]  pool [8];
    logic [47:0] r0;
    logic [31:0] r1;

    initial begin
        pool = '{8'h00, 8'h50, 8'h4F, 8'h52, 8'h04, 8'h07, 8'h1A, 8'h00};
        #2;
        // Reset held with keys present, reset also overrides frame_tick
        step(1'b0, 1'b1, 48'h1A50, 32'h1A50);
        step(1'b0, 1'b1, 48'h1A50, 32'h1A50);
        chk("rst_kb", kb[0], 16'h0000);
        chk("rst_kg", kg[1], 16'h0000);
        step(1'b1, 1'b1, 48'h1A50, 32'h1A50);
`ifndef KEYCODE_ARBITER_DEBOUNCE_EN
        chk("plan_kb", kb[0], 16'h0050);
        chk("plan_kg", kg[0], 16'h1A00);
        chk("plan_jg", {15'h0, jg[0]}, 16'h0001);
`endif
        step(1'b1, 1'b0, 48'h1A50, 32'h1A50);
        chk("plan_jg_off", {15'h0, jg[0]}, 16'h0000);

        // Left+right conflict, then add up
        step(1'b1, 1'b1, 48'h4F50, 32'h4F50);
        step(1'b1, 1'b1, 48'h4F50, 32'h4F50);
        step(1'b1, 1'b1, 48'h524F50, 32'h524F50);
        step(1'b1, 1'b0, 48'h524F50, 32'h524F50);
        step(1'b1, 1'b1, 48'h524F50, 32'h524F50);

        // Last-pressed: girl left, then left+right, drop right, idle, both at once
        for (int rep = 0; rep < 2; rep++) begin
            step(1'b1, 1'b1, 48'h04, 32'h04);
            step(1'b1, 1'b1, 48'h0704, 32'h0704);
            step(1'b1, 1'b1, 48'h0704, 32'h0704);
            step(1'b1, 1'b1, 48'h04, 32'h04);
            step(1'b1, 1'b1, 48'h0, 32'h0);
            step(1'b1, 1'b1, 48'h0704, 32'h0704);
            step(1'b1, 1'b1, 48'h0704, 32'h0704);
        end
`ifndef KEYCODE_ARBITER_DEBOUNCE_EN
        chk("socd_both", kg[1], 16'h0000);
`endif

        // Up held, released, pressed again; then no ticks for 10 cycles
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 48'h1A52, 32'h1A52);
        step(1'b1, 1'b1, 48'h0, 32'h0);
        step(1'b1, 1'b1, 48'h1A52, 32'h1A52);
        step(1'b1, 1'b1, 48'h1A52, 32'h1A52);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 48'h4F07, 32'h4F07);

        // Top slot of the 6-slot dut, then all empty; debounce single-tick blip
        step(1'b1, 1'b1, 48'h50_00_00_00_00_00, 32'h0);
        step(1'b1, 1'b1, 48'h50_00_00_00_00_00, 32'h0);
        step(1'b1, 1'b1, 48'h0, 32'h0);
        step(1'b1, 1'b1, 48'h50, 32'h50);
        step(1'b1, 1'b1, 48'h0, 32'h0);
        step(1'b1, 1'b1, 48'h50, 32'h50);
        step(1'b1, 1'b1, 48'h50, 32'h50);
        step(1'b1, 1'b1, 48'h0, 32'h0);

        // Random traffic: slots mutate slowly so presses persist across ticks
        r0 = '0;
        r1 = '0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int s;
                s = $urandom_range(0, 5);
                r0[8*s +: 8] = pool[$urandom_range(0, 7)];
                s = $urandom_range(0, 3);
                r1[8*s +: 8] = pool[$urandom_range(0, 7)];
            end
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), r0, r1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keycode_arbiter.md
Name: keycode_arbiter

Overview:
Parametrised, registered successor to the two-player keycode splitter. It scans SLOTS packed 8-bit USB keycodes and decodes per-player left/right/up from parameter keymaps. Horizontal conflicts are resolved by a selectable SOCD mode, and the block produces one-cycle jump pulses. Sampling is on frame_tick (VGA vsync-derived), so the fireboy/watergirl motion FSMs see a stable input for a whole frame.

Parameters:
SLOTS, 4, number of 8-bit keycode slots in keycodes; slot value 8'h00 = empty
SOCD_MODE, 0, 0 = neutral (left+right held -> no horizontal), 1 = last-pressed wins
BOY_LEFT, 8'h50, boy left keycode
BOY_RIGHT, 8'h4F, boy right keycode
BOY_UP, 8'h52, boy up keycode
GIRL_LEFT, 8'h04, girl left keycode
GIRL_RIGHT, 8'h07, girl right keycode
GIRL_UP, 8'h1A, girl up keycode

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous reset, active-low
frame_tick  in  1  one-cycle strobe; sample and update enable
keycodes  in  8*SLOTS  packed slots; slot i = keycodes[8*i+7:8*i]
keycode_boy  out  16  [15:8] = 8'h52 if up else 0; [7:0] = 8'h50 / 8'h4F / 0
keycode_girl  out  16  [15:8] = 8'h1A if up else 0; [7:0] = 8'h04 / 8'h07 / 0
jump_boy  out  1  one-cycle pulse on boy up press edge
jump_girl  out  1  one-cycle pulse on girl up press edge
conflict_boy  out  1  left and right both currently recognised as pressed (boy)
conflict_girl  out  1  same, girl

Behaviour:
- Reset (Reset_n=0 at a Clk edge): all outputs 0; prev-pressed flags 0; last_dir = NONE for both players. Reset overrides frame_tick.
- Decode (combinational): key K is raw-pressed if any slot equals K. Duplicate slots are harmless. A keymap parameter of 8'h00 never matches, because empty slots are ignored.
- Everything below updates only on a Clk edge with frame_tick=1. Outputs are registered: visible the cycle after the tick. Between ticks all outputs hold, except the jump pulses.
- Per player, L = left pressed, R = right pressed, pL/pR = previous-tick values:
  - last_dir update: if L rose and R did not, last_dir = LEFT. If R rose and L did not, last_dir = RIGHT. If both rose on the same tick, last_dir = NONE. If neither rose, last_dir holds.
  - Horizontal output: L only -> left code. R only -> right code. Neither -> 0.
  - L and R together: SOCD_MODE=0 -> 0. SOCD_MODE=1 -> code of last_dir, or 0 if last_dir = NONE.
  - conflict = L & R.
  - Up field = up code when up pressed, else 0. Up is independent of horizontal.
  - jump = 1 when up pressed now and not at the previous tick. It is high for exactly the one cycle after the tick, then 0 regardless of frame_tick.
- Back-to-back frame_tick every cycle is legal: each cycle is a full update.
- The two players are fully independent; no cross-player interaction.

Optional Feature:
KEYCODE_ARBITER_DEBOUNCE_EN
- Defined: each of the six keys has a 1-bit confirm register. A key is recognised pressed only when raw-pressed on two consecutive ticks. Release is recognised on the first tick the key is absent. Edges, last_dir, jump and conflict all use recognised state, so press latency is 2 ticks and release latency is 1 tick.
- Undefined: recognised state = raw state; no confirm registers are synthesised.

Test Plan:
- Reset_n=0 for 2 cycles with keycodes holding 8'h50 and 8'h1A -> all outputs 0; after release and one tick: keycode_boy=16'h0050, keycode_girl=16'h1A00, jump_girl=1 for one cycle.
- SOCD_MODE=0, keycodes = {..,8'h50,8'h4F} on a tick -> keycode_boy=16'h0000, conflict_boy=1; add 8'h52 on the next tick -> 16'h5200, jump_boy pulses once.
- SOCD_MODE=1: tick with 8'h04 only, then tick with 8'h04+8'h07 -> keycode_girl=16'h0007; drop 8'h07 -> 16'h0004; both rising on the same tick from idle -> 16'h0000.
- Up held for 5 ticks -> jump pulses once (cycle after first tick); release 1 tick, press again -> second pulse; no frame_tick for 10 cycles -> outputs frozen, jump 0.
- SLOTS=6: key in top slot (bits 47:40) only -> decoded; all slots 8'h00 -> both outputs 16'h0000, no conflict.
- KEYCODE_ARBITER_DEBOUNCE_EN defined: 8'h50 present for one tick then absent -> keycode_boy stays 0; present for 2 ticks -> 16'h0050 after the second tick; absent one tick -> 0.
